// File: rtl/pwm.sv
// Pulse-width modulator: a WIDTH-bit level is latched once per period of
// 2^WIDTH-1 steps, and the output is high for that many steps.
module pwm #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_lvl,
  output logic             o_pwm,
  output logic             o_sync
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic             bnd_q, bnd_d;
  logic             pwm_q, pwm_d;
  logic             sync_q, sync_d;
  logic             tick;

  always_comb begin
    tick   = (pre_q == PRE_LAST);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    bnd_d  = 1'b0;
    if (tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        lvl_d = i_lvl;
        bnd_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // The counter never reaches MAX, so a MAX level keeps the output high across the wrap.
    pwm_d  = (cnt_q < lvl_q);
    // Boundary flag is delayed one clock so the strobe lines up with the first step of the new period.
    sync_d = bnd_q;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      lvl_q  <= '0;
      bnd_q  <= 1'b0;
      pwm_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      bnd_q  <= bnd_d;
      pwm_q  <= pwm_d;
      sync_q <= sync_d;
    end
  end

  assign o_pwm  = pwm_q;
  assign o_sync = sync_q;

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: default instance (PRESCALE=1) and a PRESCALE=4 instance.
module tb_pwm;

  logic       clk = 1'b0;
  logic       rst  = 1'b1;
  logic       rst4 = 1'b1;
  logic [3:0] lvl  = 4'd0;
  logic [3:0] lvl4 = 4'd0;
  logic       pwm_o, sync_o, pwm4_o, sync4_o;
  int         total = 0;
  int         bad   = 0;
  int         e     = 0;

  always #5 clk = ~clk;

  pwm #(.WIDTH(4), .PRESCALE(1)) dut (
    .clk(clk), .i_rst(rst), .i_lvl(lvl), .o_pwm(pwm_o), .o_sync(sync_o)
  );

  pwm #(.WIDTH(4), .PRESCALE(4)) dut4 (
    .clk(clk), .i_rst(rst4), .i_lvl(lvl4), .o_pwm(pwm4_o), .o_sync(sync4_o)
  );

  // Edge e counts rising edges after reset release; period p = (e-1)/(15*per).
  function automatic logic exp_pwm(int ev, int per, int lv);
    int s;
    if ((ev - 1) / (15 * per) == 0) return 1'b0;
    s = ((ev - 1) % (15 * per)) / per;
    return (s < lv);
  endfunction

  function automatic logic exp_sync(int ev, int per);
    return ((ev - 1) % (15 * per) == 0) && ((ev - 1) / (15 * per) >= 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic test_reset();
    lvl = 4'b1000;
    do_reset();
    while (e < 20) step();
    total++;
    if (pwm_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_high e=%0d got=%b want=1", e, pwm_o);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (pwm_o !== 1'b0 || sync_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got pwm=%b sync=%b want 0/0", pwm_o, sync_o);
    end
    step();
    total++;
    if (pwm_o !== 1'b0 || sync_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_held got pwm=%b sync=%b want 0/0", pwm_o, sync_o);
    end
    rst = 1'b0;
    e   = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      total++;
      if (pwm_o !== exp_pwm(e, 1, 8) || sync_o !== exp_sync(e, 1)) begin
        bad++;
        $display("FAIL rst_after e=%0d got pwm=%b sync=%b want pwm=%b sync=%b",
                 e, pwm_o, sync_o, exp_pwm(e, 1, 8), exp_sync(e, 1));
      end
    end
  endtask

  task automatic test_duty_low();
    lvl = 4'b0010;
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      step();
      total++;
      if (pwm_o !== exp_pwm(e, 1, 2) || sync_o !== exp_sync(e, 1)) begin
        bad++;
        $display("FAIL duty2 e=%0d got pwm=%b sync=%b want pwm=%b sync=%b",
                 e, pwm_o, sync_o, exp_pwm(e, 1, 2), exp_sync(e, 1));
      end
    end
  endtask

  task automatic test_full();
    lvl = 4'b1111;
    do_reset();
    for (int i = 0; i < 75; i++) begin
      step();
      total++;
      if (pwm_o !== (e > 15) || sync_o !== exp_sync(e, 1)) begin
        bad++;
        $display("FAIL full e=%0d got pwm=%b sync=%b want pwm=%b sync=%b",
                 e, pwm_o, sync_o, (e > 15), exp_sync(e, 1));
      end
    end
  endtask

  task automatic test_zero();
    lvl = 4'b0000;
    do_reset();
    for (int i = 0; i < 75; i++) begin
      step();
      total++;
      if (pwm_o !== 1'b0 || sync_o !== exp_sync(e, 1)) begin
        bad++;
        $display("FAIL zero e=%0d got pwm=%b sync=%b want pwm=0 sync=%b",
                 e, pwm_o, sync_o, exp_sync(e, 1));
      end
    end
  endtask

  // Period levels: p1 latched 8; mid-period change to 14 shows in p2;
  // change just before the p3 boundary edge latches 3; change just after it waits for p4.
  task automatic test_level_change();
    int per_lvl [6] = '{0, 8, 14, 3, 9, 9};
    int lv;
    lvl = 4'b1000;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      if (e == 18) lvl = 4'b1110;
      if (e == 44) lvl = 4'b0011;
      if (e == 45) lvl = 4'b1001;
      step();
      lv = per_lvl[(e - 1) / 15];
      total++;
      if (pwm_o !== exp_pwm(e, 1, lv) || sync_o !== exp_sync(e, 1)) begin
        bad++;
        $display("FAIL lvl_change e=%0d got pwm=%b sync=%b want pwm=%b sync=%b",
                 e, pwm_o, sync_o, exp_pwm(e, 1, lv), exp_sync(e, 1));
      end
    end
  endtask

  task automatic test_prescale();
    lvl4 = 4'b0010;
    rst4 = 1'b1;
    step();
    step();
    rst4 = 1'b0;
    e    = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      total++;
      if (pwm4_o !== exp_pwm(e, 4, 2) || sync4_o !== exp_sync(e, 4)) begin
        bad++;
        $display("FAIL prescale4 e=%0d got pwm=%b sync=%b want pwm=%b sync=%b",
                 e, pwm4_o, sync4_o, exp_pwm(e, 4, 2), exp_sync(e, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty_low();
    test_full();
    test_zero();
    test_level_change();
    test_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Parameterised pulse-width modulator: converts a WIDTH-bit level code into a fixed-period, duty-proportional digital output.
- Typically drives LED/segment brightness, e.g. dimming for the seven-segment driver.
- Level is sampled once per PWM period, so the output never glitches mid-period.
- Optional clock prescaler slows the PWM step rate.

Parameters:
- WIDTH, 4, bit width of i_lvl and of the period counter.
- PRESCALE, 1, system clocks per PWM step (integer ≥1); 1 = step every clock.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_lvl  input  WIDTH  requested duty level, 0 to 2^WIDTH-1.
- o_pwm  output  1  PWM output, registered.
- o_sync  output  1  one-clock strobe marking the start of each PWM period (level-latch point), registered.

Behaviour:
- Constants:
  - MAX = 2^WIDTH-1.
  - Period = MAX steps, i.e. MAX*PRESCALE clocks (15 clocks at defaults).
- Reset (i_rst high, asynchronous, takes effect immediately, also mid-period):
  - o_pwm=0, o_sync=0.
  - Step counter cnt=0, latched level lvl_q=0, prescaler pre=0.
- Prescaler:
  - pre counts 0..PRESCALE-1 and wraps.
  - tick=1 in the clock where pre==PRESCALE-1.
  - With PRESCALE=1, tick is constantly 1.
- Step counter (WIDTH bits), on tick:
  - if cnt==MAX-1: cnt<=0 and lvl_q<=i_lvl (period boundary);
  - else cnt<=cnt+1.
  - cnt never reaches MAX.
- No tick: cnt and lvl_q hold.
- Output, every clock:
  - o_pwm <= (cnt < lvl_q), unsigned compare.
  - One clock of latency from counter state to pin.
- o_sync: o_sync <= 1 in the clock after a tick with cnt==MAX-1, i.e. aligned with the first o_pwm of the new period; 0 otherwise.
- Duty: o_pwm high for exactly lvl_q of every MAX steps.
  - lvl=0: constantly low.
  - lvl=MAX: constantly high, with no 1-clock low gap at wrap.
- Level changes:
  - i_lvl is ignored except at the period boundary.
  - A change mid-period takes effect at the start of the next period.
  - i_lvl can change on any cycle with no handshake.
- After reset release:
  - lvl_q=0, so the first full period is all low (15 clocks at defaults).
  - The i_lvl value present at the first boundary then applies.
- Boundary: i_lvl changing in the same clock as the boundary tick latches the new value.
- No combinational path from i_lvl to o_pwm.

Test Plan (WIDTH=4, PRESCALE=1 unless noted):
- Assert i_rst mid-period with i_lvl=4'b1000 → o_pwm=0 immediately, with no clock edge. After release, the first 15 clocks are low, then 8 high / 7 low repeating.
- i_lvl=4'b0010 held 5000 clocks → each 15-clock period shows 2 high then 13 low. o_sync pulses every 15 clocks, coincident with the first high clock.
- i_lvl=4'b1111 → o_pwm continuously 1 from the first period after latch, with no low cycle at any wrap.
- i_lvl=4'b0000 → o_pwm continuously 0; o_sync still pulses every 15 clocks.
- Change i_lvl 4'b1000→4'b1110 at cnt=3 → the current period completes as 8 high / 7 low; the next period is 14 high / 1 low.
- PRESCALE=4, i_lvl=4'b0010 → period 60 clocks; o_pwm high 8 clocks then low 52; o_sync one clock wide every 60 clocks.
